// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants: opcode classes, PC/address mux codes, vectors
// and the IF/ID assembler state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_TWO_BYTE = 4'd12;
  localparam logic [3:0] OP_BRANCH   = 4'd11;

  localparam logic [1:0] PC_SRC_RB_EX = 2'b00;
  localparam logic [1:0] PC_SRC_IMEM  = 2'b01;
  localparam logic [1:0] PC_SRC_RB_D  = 2'b10;
  localparam logic [1:0] PC_SRC_DMEM  = 2'b11;

  localparam logic [1:0] ADDR_SRC_PC      = 2'b00;
  localparam logic [1:0] ADDR_SRC_VEC_RST = 2'b01;
  localparam logic [1:0] ADDR_SRC_VEC_INT = 2'b10;
  localparam logic [1:0] ADDR_SRC_PC_ALT  = 2'b11;

  localparam logic [7:0] VEC_RESET = 8'h00;
  localparam logic [7:0] VEC_INT   = 8'h01;
  localparam logic [7:0] NOP       = 8'h00;

  typedef enum logic {
    A_OP  = 1'b0,
    A_IMM = 1'b1
  } asm_state_e;

endpackage

// File: rtl/ifid_assembler.sv
// Builds complete IF/ID entries from the fetched byte stream; also captures the
// interrupt return address, rewinding to the opcode of a half-fetched instruction.
module ifid_assembler
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_sf1,
  input  logic [DATA_W-1:0] i_byte,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_pc,
  output asm_state_e        o_state,
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_imm,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_ret_pc,
  output logic              o_ret_valid
);

  asm_state_e        r_state, w_state_nx;
  logic [DATA_W-1:0] r_first_byte, w_first_byte_nx;
  logic [ADDR_W-1:0] r_first_addr, w_first_addr_nx;
  logic [DATA_W-1:0] r_instr, w_instr_nx, r_imm, w_imm_nx;
  logic [ADDR_W-1:0] r_pc_next, w_pc_next_nx;
  logic              r_valid, w_valid_nx;
  logic [ADDR_W-1:0] r_ret_pc, w_ret_pc_nx;
  logic              r_ret_valid, w_ret_valid_nx;
  logic [ADDR_W-1:0] w_addr_inc;

  assign w_addr_inc = i_addr + ADDR_W'(1);

  always_comb begin
    w_state_nx      = r_state;
    w_first_byte_nx = r_first_byte;
    w_first_addr_nx = r_first_addr;
    w_instr_nx      = r_instr;
    w_imm_nx        = r_imm;
    w_pc_next_nx    = r_pc_next;
    w_valid_nx      = r_valid;
    w_ret_pc_nx     = r_ret_pc;
    w_ret_valid_nx  = i_sf1;
    if (i_sf1)
      w_ret_pc_nx = (r_state == A_IMM) ? r_first_addr : i_pc;
    // Flush and interrupt entry override stall and drop any held opcode.
    if (i_flush || i_sf1) begin
      w_instr_nx = DATA_W'(NOP);
      w_valid_nx = 1'b0;
      w_state_nx = A_OP;
    end else if (!i_stall) begin
      case (r_state)
        A_OP: begin
          if (i_byte[DATA_W-1 -: 4] == OP_TWO_BYTE) begin
            w_first_byte_nx = i_byte;
            w_first_addr_nx = i_addr;
            w_valid_nx      = 1'b0;
            w_state_nx      = A_IMM;
          end else begin
            w_instr_nx   = i_byte;
            w_imm_nx     = '0;
            w_pc_next_nx = w_addr_inc;
            w_valid_nx   = 1'b1;
          end
        end
        A_IMM: begin
          w_instr_nx   = r_first_byte;
          w_imm_nx     = i_byte;
          w_pc_next_nx = w_addr_inc;
          w_valid_nx   = 1'b1;
          w_state_nx   = A_OP;
        end
        default: w_state_nx = A_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= A_OP;
      r_first_byte <= '0;
      r_first_addr <= '0;
      r_instr      <= '0;
      r_imm        <= '0;
      r_pc_next    <= '0;
      r_valid      <= 1'b0;
      r_ret_pc     <= '0;
      r_ret_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_first_byte <= w_first_byte_nx;
      r_first_addr <= w_first_addr_nx;
      r_instr      <= w_instr_nx;
      r_imm        <= w_imm_nx;
      r_pc_next    <= w_pc_next_nx;
      r_valid      <= w_valid_nx;
      r_ret_pc     <= w_ret_pc_nx;
      r_ret_valid  <= w_ret_valid_nx;
    end
  end

  assign o_state     = r_state;
  assign o_instr     = r_instr;
  assign o_imm       = r_imm;
  assign o_pc_next   = r_pc_next;
  assign o_valid     = r_valid;
  assign o_ret_pc    = r_ret_pc;
  assign o_ret_valid = r_ret_valid;

endmodule

// File: rtl/fetch_datapath.sv
// Fetch-stage datapath: program counter, instruction address mux and the IF/ID
// assembler, steered by the fetch control unit.
module fetch_datapath
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              pc_load,
  input  logic [1:0]        pc_src,
  input  logic [1:0]        addr_src,
  input  logic              stall,
  input  logic              sf1,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rb_ex,
  input  logic [ADDR_W-1:0] rb_d,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        fetch_opcode,
  output logic [1:0]        fetch_brx,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_imm,
  output logic [ADDR_W-1:0] ifid_pc_next,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] int_ret_pc,
  output logic              int_ret_valid
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_target;
  logic [ADDR_W-1:0] w_imem_addr;
  asm_state_e        w_state;

  always_comb begin
    case (pc_src)
      PC_SRC_RB_EX: w_pc_target = rb_ex;
      PC_SRC_IMEM:  w_pc_target = ADDR_W'(imem_rdata);
      PC_SRC_RB_D:  w_pc_target = rb_d;
      default:      w_pc_target = ADDR_W'(dmem_rdata);
    endcase
  end

  always_comb begin
    case (addr_src)
      ADDR_SRC_VEC_RST: w_imem_addr = ADDR_W'(VEC_RESET);
      ADDR_SRC_VEC_INT: w_imem_addr = ADDR_W'(VEC_INT);
      default:          w_imem_addr = r_pc;
    endcase
  end

  // Stall is not applied here: the control unit holds the PC by dropping pc_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_pc <= '0;
    else if (pc_en)
      r_pc <= pc_load ? w_pc_target : r_pc + ADDR_W'(1);
  end

  ifid_assembler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (stall),
    .i_flush    (flush),
    .i_sf1      (sf1),
    .i_byte     (imem_rdata),
    .i_addr     (w_imem_addr),
    .i_pc       (r_pc),
    .o_state    (w_state),
    .o_instr    (ifid_instr),
    .o_imm      (ifid_imm),
    .o_pc_next  (ifid_pc_next),
    .o_valid    (ifid_valid),
    .o_ret_pc   (int_ret_pc),
    .o_ret_valid(int_ret_valid)
  );

  // An immediate byte on the bus must not look like an opcode to the control unit.
  assign fetch_opcode = (w_state == A_OP) ? imem_rdata[DATA_W-1 -: 4] : 4'd0;
  assign fetch_brx    = (w_state == A_OP) ? imem_rdata[DATA_W-5 -: 2] : 2'd0;
  assign imem_addr    = w_imem_addr;
  assign pc           = r_pc;

endmodule

// File: tb/tb_fetch_datapath.sv
// Bench for fetch_datapath: directed scenarios plus a randomized run, all
// compared against a transaction-level model of the fetch stage.
module tb_fetch_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_en, pc_load, stall, sf1, flush;
  logic [1:0] pc_src, addr_src;
  logic [7:0] rb_ex, rb_d, dmem_rdata;
  logic [7:0] imem_addr, imem_rdata, pc;
  logic [3:0] fetch_opcode;
  logic [1:0] fetch_brx;
  logic [7:0] ifid_instr, ifid_imm, ifid_pc_next, int_ret_pc;
  logic       ifid_valid, int_ret_valid;

  logic [7:0] imem [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign imem_rdata = imem[imem_addr];

  fetch_datapath #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_load(pc_load), .pc_src(pc_src),
    .addr_src(addr_src), .stall(stall), .sf1(sf1), .flush(flush), .rb_ex(rb_ex),
    .rb_d(rb_d), .dmem_rdata(dmem_rdata), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .fetch_opcode(fetch_opcode), .fetch_brx(fetch_brx), .ifid_instr(ifid_instr),
    .ifid_imm(ifid_imm), .ifid_pc_next(ifid_pc_next), .ifid_valid(ifid_valid),
    .int_ret_pc(int_ret_pc), .int_ret_valid(int_ret_valid)
  );

  // Reference model: "pending" means an opcode 12 byte is waiting for its immediate.
  logic [7:0] m_pc, m_fb, m_fa, m_instr, m_imm, m_next, m_rpc;
  bit         m_pend, m_valid, m_rv;

  task automatic model_reset();
    m_pc = 0; m_fb = 0; m_fa = 0; m_instr = 0; m_imm = 0; m_next = 0; m_rpc = 0;
    m_pend = 0; m_valid = 0; m_rv = 0;
  endtask

  function automatic logic [7:0] m_addr();
    if (addr_src == 2'b01) return 8'h00;
    if (addr_src == 2'b10) return 8'h01;
    return m_pc;
  endfunction

  function automatic logic [13:0] exp_comb();
    logic [7:0] b;
    b = imem[m_addr()];
    return m_pend ? {m_addr(), 6'd0} : {m_addr(), b[7:4], b[3:2]};
  endfunction

  function automatic logic [41:0] exp_state();
    return {m_pc, m_instr, m_imm, m_next, m_valid, m_rpc, m_rv};
  endfunction

  function automatic logic [41:0] dut_state();
    return {pc, ifid_instr, ifid_imm, ifid_pc_next, ifid_valid, int_ret_pc, int_ret_valid};
  endfunction

  task automatic idle();
    pc_en = 0; pc_load = 0; pc_src = 0; addr_src = 0; stall = 0; sf1 = 0; flush = 0;
    rb_ex = 0; rb_d = 0; dmem_rdata = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance the model by one fetch cycle using the inputs now applied, then clock the DUT.
  task automatic tick();
    logic [7:0] a, b, tgt, npc;
    a = m_addr();
    b = imem[a];
    case (pc_src)
      2'b00: tgt = rb_ex;
      2'b01: tgt = b;
      2'b10: tgt = rb_d;
      default: tgt = dmem_rdata;
    endcase
    npc = m_pc;
    if (pc_en) npc = pc_load ? tgt : m_pc + 8'd1;
    m_rv = sf1;
    if (sf1) m_rpc = m_pend ? m_fa : m_pc;
    if (flush || sf1) begin
      m_instr = 8'h00; m_valid = 0; m_pend = 0;
    end else if (!stall) begin
      if (m_pend) begin
        m_instr = m_fb; m_imm = b; m_next = a + 8'd1; m_valid = 1; m_pend = 0;
      end else if (b[7:4] == 4'd12) begin
        m_fb = b; m_fa = a; m_valid = 0; m_pend = 1;
      end else begin
        m_instr = b; m_imm = 8'h00; m_next = a + 8'd1; m_valid = 1;
      end
    end
    m_pc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_state() !== 42'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", dut_state());
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({imem_addr, fetch_opcode, fetch_brx} !== exp_comb() || dut_state() !== 42'd0) begin
      n_err++;
      $display("FAIL reset_held got addr=%h st=%h want addr=%h st=0", imem_addr, dut_state(), m_addr());
    end
  endtask

  task automatic test_boot();
    imem[8'h00] = 8'h10;
    reset = 1'b1;
    pc_en = 1; pc_load = 1; pc_src = 2'b01; addr_src = 2'b01;
    settle();
    tick();
    n_cmp++;
    if (pc !== 8'h10 || dut_state() !== exp_state()) begin
      n_err++;
      $display("FAIL boot_vector got pc=%h st=%h want pc=10 st=%h", pc, dut_state(), exp_state());
    end
  endtask

  task automatic test_one_byte();
    imem[8'h10] = 8'h21; imem[8'h11] = 8'h32;
    idle(); pc_en = 1;
    settle();
    tick();
    n_cmp++;
    if ({ifid_instr, ifid_pc_next, ifid_valid} !== {8'h21, 8'h11, 1'b1}) begin
      n_err++;
      $display("FAIL one_byte_first got instr=%h next=%h v=%b want 21 11 1", ifid_instr, ifid_pc_next, ifid_valid);
    end
    settle();
    tick();
    n_cmp++;
    if ({ifid_instr, ifid_imm, ifid_pc_next, ifid_valid} !== {8'h32, 8'h00, 8'h12, 1'b1} || dut_state() !== exp_state()) begin
      n_err++;
      $display("FAIL one_byte_second got instr=%h imm=%h next=%h v=%b want 32 00 12 1", ifid_instr, ifid_imm, ifid_pc_next, ifid_valid);
    end
  endtask

  task automatic test_two_byte();
    imem[8'h20] = 8'hC4; imem[8'h21] = 8'h7F;
    idle(); pc_en = 1; pc_load = 1; pc_src = 2'b00; rb_ex = 8'h20; flush = 1;
    settle();
    tick();
    idle(); pc_en = 1;
    settle();
    n_cmp++;
    if (fetch_opcode !== 4'hC || fetch_brx !== 2'b01) begin
      n_err++;
      $display("FAIL two_byte_opcode got op=%h brx=%b want c 01", fetch_opcode, fetch_brx);
    end
    tick();
    n_cmp++;
    if (ifid_valid !== 1'b0 || fetch_opcode !== 4'd0 || fetch_brx !== 2'd0) begin
      n_err++;
      $display("FAIL two_byte_gap got v=%b op=%h brx=%b want 0 0 0", ifid_valid, fetch_opcode, fetch_brx);
    end
    settle();
    tick();
    n_cmp++;
    if ({ifid_instr, ifid_imm, ifid_pc_next, ifid_valid} !== {8'hC4, 8'h7F, 8'h22, 1'b1}) begin
      n_err++;
      $display("FAIL two_byte_entry got %h %h %h %b want c4 7f 22 1", ifid_instr, ifid_imm, ifid_pc_next, ifid_valid);
    end
  endtask

  task automatic test_stall_flush();
    imem[8'h22] = 8'hC9; imem[8'h23] = 8'h55; imem[8'h24] = 8'hC1; imem[8'h25] = 8'h66;
    idle(); pc_en = 1;
    settle();
    tick();
    idle(); stall = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      tick();
      n_cmp++;
      if (dut_state() !== exp_state() || ifid_valid !== 1'b0 || pc !== 8'h23) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got st=%h want %h", i, dut_state(), exp_state());
      end
    end
    idle(); pc_en = 1;
    settle();
    tick();
    n_cmp++;
    if ({ifid_instr, ifid_imm, ifid_pc_next, ifid_valid} !== {8'hC9, 8'h55, 8'h24, 1'b1}) begin
      n_err++;
      $display("FAIL stall_release got %h %h %h %b want c9 55 24 1", ifid_instr, ifid_imm, ifid_pc_next, ifid_valid);
    end
    settle();
    tick();
    idle(); flush = 1; stall = 1;
    settle();
    tick();
    idle();
    settle();
    n_cmp++;
    if (ifid_instr !== 8'h00 || ifid_valid !== 1'b0 || fetch_opcode !== 4'h6 || dut_state() !== exp_state()) begin
      n_err++;
      $display("FAIL flush_in_imm got instr=%h v=%b op=%h want 00 0 6", ifid_instr, ifid_valid, fetch_opcode);
    end
  endtask

  task automatic test_sf1();
    imem[8'h30] = 8'hC2;
    idle(); pc_en = 1; pc_load = 1; rb_ex = 8'h30; flush = 1;
    settle();
    tick();
    idle(); pc_en = 1;
    settle();
    tick();
    idle(); sf1 = 1; pc_en = 1; pc_load = 1; pc_src = 2'b10; rb_d = 8'h77; addr_src = 2'b10;
    settle();
    tick();
    n_cmp++;
    if ({int_ret_pc, int_ret_valid, ifid_instr, ifid_valid, pc} !== {8'h30, 1'b1, 8'h00, 1'b0, 8'h77}) begin
      n_err++;
      $display("FAIL sf1_capture got ret=%h rv=%b instr=%h v=%b pc=%h want 30 1 00 0 77",
               int_ret_pc, int_ret_valid, ifid_instr, ifid_valid, pc);
    end
    idle(); stall = 1;
    settle();
    tick();
    n_cmp++;
    if (int_ret_valid !== 1'b0 || int_ret_pc !== 8'h30) begin
      n_err++;
      $display("FAIL sf1_pulse got rv=%b ret=%h want 0 30", int_ret_valid, int_ret_pc);
    end
  endtask

  task automatic test_wrap();
    idle(); pc_en = 1; pc_load = 1; rb_ex = 8'hFF; flush = 1;
    settle();
    tick();
    pc_load = 0;
    settle();
    tick();
    n_cmp++;
    if (pc !== 8'h00) begin
      n_err++;
      $display("FAIL pc_wrap got %h want 00", pc);
    end
    pc_load = 1; pc_src = 2'b11; dmem_rdata = 8'h55;
    settle();
    tick();
    n_cmp++;
    if (pc !== 8'h55 || dut_state() !== exp_state()) begin
      n_err++;
      $display("FAIL pc_dmem got pc=%h st=%h want pc=55 st=%h", pc, dut_state(), exp_state());
    end
  endtask

  task automatic test_reset_mid();
    imem[8'h40] = 8'hC7; imem[8'h00] = 8'h23;
    idle(); pc_en = 1; pc_load = 1; rb_ex = 8'h40; flush = 1;
    settle();
    tick();
    idle(); pc_en = 1;
    settle();
    tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_state() !== 42'd0) begin
      n_err++;
      $display("FAIL reset_async got %h want 0", dut_state());
    end
    reset = 1'b1;
    settle();
    tick();
    n_cmp++;
    if ({ifid_instr, ifid_imm, ifid_valid, pc} !== {8'h23, 8'h00, 1'b1, 8'h01}) begin
      n_err++;
      $display("FAIL reset_drops_held got instr=%h imm=%h v=%b pc=%h want 23 00 1 01", ifid_instr, ifid_imm, ifid_valid, pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++)
      imem[i] = ($urandom_range(0, 2) == 0) ? {4'd12, 4'($urandom)} : 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      pc_en      = ($urandom_range(0, 3) != 0);
      pc_load    = ($urandom_range(0, 4) == 0);
      pc_src     = 2'($urandom);
      addr_src   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      stall      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      sf1        = ($urandom_range(0, 15) == 0);
      rb_ex      = 8'($urandom);
      rb_d       = 8'($urandom);
      dmem_rdata = 8'($urandom);
      settle();
      n_cmp++;
      if ({imem_addr, fetch_opcode, fetch_brx} !== exp_comb()) begin
        n_err++;
        $display("FAIL rand_comb[%0d] got %h want %h", c, {imem_addr, fetch_opcode, fetch_brx}, exp_comb());
      end
      tick();
      n_cmp++;
      if (dut_state() !== exp_state()) begin
        n_err++;
        $display("FAIL rand_state[%0d] got %h want %h", c, dut_state(), exp_state());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    model_reset();
    test_reset();
    test_boot();
    test_one_byte();
    test_two_byte();
    test_stall_flush();
    test_sf1();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_datapath.md
# fetch_datapath

Datapath half of the fetch stage: owns the program counter, the instruction-memory address mux and the IF/ID pipeline register, all steered by the fetch control unit's pc_en/pc_load/pc_src/addr_src/stall/sf1 outputs. It assembles one- and two-byte instructions into complete IF/ID entries for decode. It feeds the current opcode/brx back to the control unit, and captures the interrupt return address when sf1 is asserted.

## Interface
- ADDR_W, 8, PC and memory address width
- DATA_W, 8, instruction byte width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pc_en  in  1  PC update enable
- pc_load  in  1  with pc_en: load PC from pc_src; otherwise increment
- pc_src  in  2  00 rb_ex, 01 imem_rdata, 10 rb_d, 11 dmem_rdata
- addr_src  in  2  00 PC, 01 vector 0x00, 10 vector 0x01, 11 PC
- stall  in  1  hold PC-independent IF/ID state
- sf1  in  1  interrupt entry: capture return PC
- flush  in  1  replace this cycle's captured byte with a bubble
- rb_ex, rb_d  in  ADDR_W  branch/jump targets from EX and ID
- dmem_rdata  in  DATA_W  data-memory return (RET/RTI)
- imem_addr  out  ADDR_W  instruction-memory address (combinational)
- imem_rdata  in  DATA_W  instruction byte; combinational read of imem_addr
- pc  out  ADDR_W  current PC
- fetch_opcode  out  4  imem_rdata[7:4] in A_OP, else 0
- fetch_brx  out  2  imem_rdata[3:2] in A_OP, else 0
- ifid_instr, ifid_imm  out  DATA_W  decoded entry; imm valid for opcode 12 only
- ifid_pc_next  out  ADDR_W  address following the entry (CALL return)
- ifid_valid  out  1  entry is a real instruction
- int_ret_pc  out  ADDR_W  saved return address
- int_ret_valid  out  1  one-cycle pulse on capture

## Operation
- PC update: pc_en&pc_load → pc ← mux(pc_src); pc_en&!pc_load → pc ← pc+1 (mod 2^ADDR_W, 0xFF wraps to 0x00); else hold. Stall does not gate PC; the control unit deasserts pc_en.
- imem_addr = addr_src mux; fetch_opcode/fetch_brx are combinational from imem_rdata.
- Assembler FSM, states A_OP (expect opcode), A_IMM (expect immediate). Capture when !stall.
  - A_OP, capture, !flush, opcode==12: hold byte and address in first_byte/first_addr → A_IMM; ifid_valid ← 0.
  - A_OP, capture, !flush, other opcode: ifid_instr ← byte, ifid_imm ← 0, ifid_pc_next ← imem_addr+1, valid ← 1.
  - A_IMM, capture, !flush: ifid_instr ← first_byte, ifid_imm ← byte, ifid_pc_next ← imem_addr+1, valid ← 1 → A_OP.
  - flush or sf1 (either state): ifid_instr ← 0x00 (NOP), valid ← 0, held byte dropped → A_OP. Flush beats stall.
  - stall, no flush/sf1: all IF/ID registers and the state hold.
- Interrupt: on sf1, int_ret_pc ← (A_IMM ? first_addr : pc), int_ret_valid ← 1 for exactly one cycle. A partially fetched two-byte instruction therefore re-executes from its opcode address.

## Timing
- Reset (async, low): pc=0x00, state A_OP, ifid_instr=0x00, ifid_imm=0x00, ifid_pc_next=0x00, ifid_valid=0, int_ret_pc=0x00, int_ret_valid=0, first_byte/first_addr=0x00. Reset mid-two-byte discards the held byte.
- Latency: byte on imem_rdata at edge N → IF/ID at N+1 for one-byte instructions. Two-byte: opcode at N, imm at N+1, valid entry at N+2, with a valid=0 slot at N+1.
- PC, IF/ID and int_ret update on the same edge; imem_addr, fetch_opcode and fetch_brx are purely combinational.
- sf1 together with pc_load in the same cycle: return address is computed from the pre-load PC.

## Structure
- Shared package cpu_pkg: OP_TWO_BYTE=4'd12, OP_BRANCH=4'd11, PC_SRC_* and ADDR_SRC_* codes, VEC_RESET=0x00, VEC_INT=0x01, NOP=8'h00, assembler state enum.
- One sub-module: ifid_assembler (FSM plus IF/ID registers). PC register and the muxes stay in the top level.

## Test plan
- Reset release, imem[0]=0x10, pc_load, pc_src=01, addr_src=01 → pc=0x10 on the next edge; all outputs read zero during reset.
- One-byte stream 0x21,0x32 at pc 0x10,0x11 → ifid_instr 0x21 (pc_next 0x11), then 0x32 (pc_next 0x12), valid=1 each cycle.
- Two-byte 0xC4,0x7F at 0x20 → slot with valid=0, then instr 0xC4, imm 0x7F, pc_next 0x22; fetch_opcode=0 while imm is on the bus.
- Stall for 2 cycles mid-A_IMM → IF/ID and state frozen; completes correctly after release. flush in A_IMM → NOP, valid=0, state A_OP.
- sf1 in A_IMM with first_addr=0x30 → int_ret_pc=0x30, int_ret_valid high exactly one cycle, entry flushed.
- pc=0xFF, pc_en=1, pc_load=0 → pc=0x00; pc_src=11 with dmem_rdata=0x55 → pc=0x55.
